// File: rtl/bcd_display_scan.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_display_scan
//  Purpose  : Multiplexed common-anode 7-segment scanner for packed BCD with
//             frame-aligned load/ack commit. Optional LEADING_ZERO_BLANK_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scan #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  ack,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  err
);

    localparam int c_DIV_W = $clog2(REFRESH_DIV);
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    logic [c_DIV_W-1:0]  r_div;
    logic [c_IDX_W-1:0]  r_idx;
    logic [4*DIGITS-1:0] r_hold;
    logic [4*DIGITS-1:0] r_shadow;
    logic                r_pending;

    logic                w_tick;
    logic                w_commit;
    logic [c_IDX_W-1:0]  w_idx_next;
    logic [4*DIGITS-1:0] w_shadow_next;
    logic [3:0]          w_nib;
    logic                w_blank;
    logic                w_zero_run;
    logic [6:0]          w_seg;
    logic                w_err;
    logic [DIGITS-1:0]   w_an;

    assign w_tick        = (r_div == c_DIV_LAST);
    assign w_commit      = w_tick && (r_idx == c_IDX_LAST) && r_pending;
    assign w_shadow_next = w_commit ? r_hold : r_shadow;

    always_comb begin
        w_idx_next = r_idx;
        if (w_tick) begin
            w_idx_next = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Outputs are decoded from next-cycle index/shadow so the registered
    // display, and the ack, line up with the new slot the cycle after tick.
    always_comb begin
        w_nib = 4'd0;
        w_an  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_idx_next == c_IDX_W'(k)) begin
                w_nib   = w_shadow_next[4*k +: 4];
                w_an[k] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        w_blank    = 1'b0;
        w_zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run && (w_shadow_next[4*k +: 4] == 4'd0);
            if ((w_idx_next == c_IDX_W'(k)) && w_zero_run) begin
                w_blank = 1'b1;
            end
        end
    end
`else
    assign w_blank    = 1'b0;
    assign w_zero_run = 1'b0;
`endif

    always_comb begin
        w_err = 1'b0;
        case (w_nib)
            4'd0:    w_seg = 7'h40;
            4'd1:    w_seg = 7'h79;
            4'd2:    w_seg = 7'h24;
            4'd3:    w_seg = 7'h30;
            4'd4:    w_seg = 7'h19;
            4'd5:    w_seg = 7'h12;
            4'd6:    w_seg = 7'h02;
            4'd7:    w_seg = 7'h78;
            4'd8:    w_seg = 7'h00;
            4'd9:    w_seg = 7'h10;
            default: begin
                w_seg = 7'h3F;
                w_err = 1'b1;
            end
        endcase
        if (w_blank) begin
            w_seg = 7'h7F;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_idx     <= '0;
            r_hold    <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
            ack       <= 1'b0;
            seg       <= 7'h7F;
            an        <= '1;
            err       <= 1'b0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_idx    <= w_idx_next;
            r_shadow <= w_shadow_next;
            // A load coinciding with commit refills hold and stays pending.
            if (load) begin
                r_hold    <= bcd_in;
                r_pending <= 1'b1;
            end else if (w_commit) begin
                r_pending <= 1'b0;
            end
            ack <= w_commit;
            seg <= w_seg;
            an  <= w_an;
            err <= w_err;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
`default_nettype none
// Scoreboard bench for bcd_display_scan (DIGITS=4, REFRESH_DIV=4).
module tb_bcd_display_scan;

    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic        load     = 1'b0;
    logic [15:0] bcd_in   = 16'h0;
    logic        ack;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        rst_seen = 1'b1;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] exp_q[$];
    logic [15:0] cur = 16'h0;
    int          slot_len = 0;
    int          last_k = -1;
    int          mon_k;
    bit          skip_len = 1'b1;
    logic [3:0]  nib;

    bcd_display_scan #(.DIGITS(DIGITS), .REFRESH_DIV(REFRESH_DIV)) dut (
        .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in),
        .ack(ack), .seg(seg), .an(an), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rst_seen <= rst;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    function automatic bit exp_blank(input logic [15:0] v, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        return (k > 0) && ((v >> (4*k)) == 16'h0);
`else
        return (v === 16'hFFFF) && (k > 8);
`endif
    endfunction

    function automatic int an_index(input logic [3:0] a);
        case (a)
            4'hE: return 0;
            4'hD: return 1;
            4'hB: return 2;
            4'h7: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected frame value on each ack and checks every slot.
    always @(negedge clk) begin
        if (rst_seen) begin
            check("reset_outputs", 32'({seg, an, ack, err}), 32'({7'h7F, 4'hF, 1'b0, 1'b0}));
            cur      = 16'h0;
            exp_q.delete();
            slot_len = 0;
            last_k   = -1;
            skip_len = 1'b1;
        end else begin
            mon_k = an_index(an);
            if (mon_k < 0) begin
                check("an_onehot", 32'(an), 32'hE);
            end else if (mon_k != last_k) begin
                if (last_k >= 0) begin
                    if (!skip_len) check("slot_len", 32'(slot_len), 32'(REFRESH_DIV));
                    check("an_sequence", 32'(mon_k), 32'((last_k + 1) % DIGITS));
                    skip_len = 1'b0;
                end else begin
                    check("first_slot", 32'(mon_k), 32'd0);
                end
                slot_len = 1;
                last_k   = mon_k;
            end else begin
                slot_len++;
            end
            if (ack) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 32'(ack), 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("ack_an", 32'(an), 32'hE);
                    check("ack_slot_start", 32'(slot_len), 32'd1);
                end
            end
            if (mon_k >= 0) begin
                nib = cur[4*mon_k +: 4];
                check("seg", 32'(seg), exp_blank(cur, mon_k) ? 32'h7F : 32'(dec(nib)));
                check("err", 32'(err), 32'(nib > 4'd9));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_slot(input logic [3:0] v);
        int n;
        n = 0;
        while (an === v && n < 200) begin cyc(); n++; end
        while (an !== v && n < 200) begin cyc(); n++; end
        if (n >= 200) check("wait_slot_timeout", 32'(an), 32'(v));
    endtask

    task automatic do_load(input logic [15:0] v);
        load   = 1'b1;
        bcd_in = v;
        cyc();
        load   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then plain 0000 frames
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        repeat (40) cyc();

        // Single load mid-frame
        wait_slot(4'hD);
        exp_q.push_back(16'h1234);
        do_load(16'h1234);
        repeat (40) cyc();

        // Two loads in one frame: latest wins, single ack
        wait_slot(4'hD);
        exp_q.push_back(16'h9876);
        do_load(16'h1111);
        cyc();
        do_load(16'h9876);
        repeat (40) cyc();

        // Non-BCD nibble
        wait_slot(4'hD);
        exp_q.push_back(16'h00A5);
        do_load(16'h00A5);
        repeat (40) cyc();

        // Reset before commit discards the pending load
        wait_slot(4'hD);
        exp_q.push_back(16'h4321);
        do_load(16'h4321);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (40) cyc();

        // Load in the frame-end tick cycle: earlier hold commits now, new one next frame
        wait_slot(4'h7);
        exp_q.push_back(16'h0042);
        exp_q.push_back(16'h0789);
        do_load(16'h0042);
        cyc();
        cyc();
        do_load(16'h0789);
        repeat (40) cyc();

        // Leading-zero patterns
        wait_slot(4'hD);
        exp_q.push_back(16'h0050);
        do_load(16'h0050);
        repeat (40) cyc();
        wait_slot(4'hD);
        exp_q.push_back(16'h0000);
        do_load(16'h0000);
        repeat (40) cyc();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
Downstream consumer of the 4-bit BCD converter stage. Takes DIGITS packed BCD nibbles and time-multiplexes them onto a common-anode 7-segment display with active-low anodes and segments. New values are accepted through a load/ack handshake and committed only at scan-frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
DIGITS, 4, number of display digits (1..8)
REFRESH_DIV, 50000, clk cycles per digit slot (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
load  input  1  request to capture bcd_in (single-cycle strobe, may repeat)
bcd_in  input  4*DIGITS  packed BCD; nibble k = bcd_in[4k+3:4k], digit 0 rightmost
ack  output  1  one-cycle pulse: held value committed to display
seg  output  7  active-low segments {g,f,e,d,c,b,a}, seg[0]=a
an  output  DIGITS  active-low digit enables, an[k] drives digit k
err  output  1  high while the displayed digit holds a non-BCD nibble (10..15)

Behaviour:
- Reset, rst=1 at a clk edge: seg=7'h7F, an=all 1, ack=0, err=0, divider=0, digit index=0, hold reg=0, shadow reg=0, pending=0. Reset mid-frame discards any pending load and emits no ack.
- Divider: counts 0..REFRESH_DIV-1 and wraps. tick is asserted when divider==REFRESH_DIV-1.
- Digit index: advances on tick, DIGITS-1 wraps to 0. Outputs are registered. an/seg/err change in the cycle after tick, so each digit is lit for exactly REFRESH_DIV cycles. Exactly one an bit is low at a time outside reset.
- Load: if load=1, hold <= bcd_in and pending <= 1. A later load before commit overwrites hold (latest wins).
- Frame end: tick while index==DIGITS-1. If pending: shadow <= hold, pending <= 0, ack=1 on the next cycle, coinciding with digit 0 of the new frame being driven.
- Load in the same cycle as a frame-end commit: the commit uses the pre-update hold value. The new bcd_in goes into hold, pending stays 1, and it is committed at the next frame end.
- Worst-case latency from load to displayed: DIGITS*REFRESH_DIV+1 cycles.
- Decode (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibbles 10..15 show a dash, 7'h3F, with err=1 for that slot.
- The display reads only the shadow reg. The hold reg never reaches the outputs directly.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: any digit k>0 whose nibble and all higher nibbles in the shadow reg are 0 drives seg=7'h7F (blank) while its an bit is still scanned low. Digit 0 is never blanked. A non-BCD nibble counts as nonzero. err is unaffected.
- Undefined: all digits are decoded and shown, including leading zeros.

Test Plan:
(All with DIGITS=4, REFRESH_DIV=4.)
1. rst=1 for 3 cycles, then released -> during reset and the first cycle after: seg=7F, an=F, ack=0, err=0. First frame shows 0000: seg=40 in every slot, an sequence E,D,B,7, each held 4 cycles.
2. load=1 with bcd_in=16'h1234 once, mid-frame -> exactly one ack pulse, one cycle after the frame-end tick. The next frame shows an E/seg 19, D/30, B/24, 7/79.
3. load 16'h1111 and then 16'h9876 within the same frame -> a single ack. The display goes straight from the old value to 9876 (seg 02, 78, 00, 10); 1111 is never shown.
4. load 16'h00A5 -> slot an=D shows seg=3F with err=1. The other slots show err=0 and seg 12, 40, 40.
5. load 16'h4321, then rst=1 for 1 cycle before the frame end -> no ack. Outputs return to reset values and the following frame shows 0000.
6. With LEADING_ZERO_BLANK_EN defined:
   - load 16'h0050 -> slots 3 and 2 seg=7F, slot 1 seg=12, slot 0 seg=40.
   - load 16'h0000 -> only slot 0 is lit, seg=40.
